// File: rtl/speed_tracker.sv
// Multi-object speed estimator: per-ID position history, |dy|*SCALE / frame gap via a
// sequential restoring divider, one result record per accepted detection.
module speed_tracker #(
    parameter int WIDTH   = 9,
    parameter int ID_W    = 8,
    parameter int FRAME_W = 8,
    parameter int SCALE   = 8,
    parameter int MAX_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ID_W-1:0]  in_id,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_speed,
    output logic             o_dir,
    output logic             o_new,
    output logic             o_over,
    output logic             o_err
);

    localparam int NUM_W   = WIDTH + 8;
    localparam int CNT_W   = $clog2(NUM_W);
    localparam int DEPTH   = 2 ** ID_W;
    localparam int ENTRY_W = 2 * WIDTH + FRAME_W;

    typedef enum logic [2:0] {IDLE, READ, CALC, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic                 clear_pend_q, clear_pend_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [FRAME_W-1:0]   stamp_q, stamp_d;
    logic                 new_q, new_d;
    logic                 err_q, err_d;
    logic                 dir_q, dir_d;
    logic [FRAME_W-1:0]   dt_q, dt_d;
    logic [NUM_W-1:0]     num_q, num_d;
    logic [FRAME_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 o_valid_q, o_valid_d;
    logic [ID_W-1:0]      o_id_q, o_id_d;
    logic [WIDTH-1:0]     o_x_q, o_x_d;
    logic [WIDTH-1:0]     o_y_q, o_y_d;
    logic [WIDTH-1:0]     o_speed_q, o_speed_d;
    logic                 o_dir_q, o_dir_d;
    logic                 o_new_q, o_new_d;
    logic                 o_over_q, o_over_d;
    logic                 o_err_q, o_err_d;

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ENTRY_W-1:0]   rd_q;
    logic                 mem_we;

    logic                 prev_valid;
    logic [WIDTH-1:0]     prev_y;
    logic [FRAME_W-1:0]   prev_stamp;
    logic [WIDTH-1:0]     unused_prev_x;
    logic [FRAME_W-1:0]   dt_calc;
    logic [WIDTH-1:0]     dy_calc;
    logic [FRAME_W:0]     rem_shift;
    logic [FRAME_W:0]     rem_diff;
    logic                 rem_fits;
    logic [WIDTH-1:0]     quot_sat;
    logic [WIDTH-1:0]     speed;

    // Table entry layout is {x, y, stamp}; x is kept for completeness but not needed for speed.
    assign prev_valid    = valid_q[id_q];
    assign prev_stamp    = rd_q[FRAME_W-1:0];
    assign prev_y        = rd_q[FRAME_W +: WIDTH];
    assign unused_prev_x = rd_q[FRAME_W+WIDTH +: WIDTH];
    assign dt_calc       = stamp_q - prev_stamp;
    assign dy_calc       = (y_q >= prev_y) ? (y_q - prev_y) : (prev_y - y_q);

    assign rem_shift = {rem_q, num_q[NUM_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dt_q};
    assign rem_fits  = (rem_shift >= {1'b0, dt_q});
    assign quot_sat  = (|num_q[NUM_W-1:WIDTH]) ? '1 : num_q[WIDTH-1:0];
    assign speed     = (new_q || err_q) ? '0 : quot_sat;

    assign in_ready = (state_q == IDLE);
    assign o_valid  = o_valid_q;
    assign o_id     = o_id_q;
    assign o_x      = o_x_q;
    assign o_y      = o_y_q;
    assign o_speed  = o_speed_q;
    assign o_dir    = o_dir_q;
    assign o_new    = o_new_q;
    assign o_over   = o_over_q;
    assign o_err    = o_err_q;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q + FRAME_W'(i_frame);
        valid_d      = valid_q;
        clear_pend_d = clear_pend_q;
        id_d         = id_q;
        x_d          = x_q;
        y_d          = y_q;
        stamp_d      = stamp_q;
        new_d        = new_q;
        err_d        = err_q;
        dir_d        = dir_q;
        dt_d         = dt_q;
        num_d        = num_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        o_valid_d    = 1'b0;
        o_id_d       = o_id_q;
        o_x_d        = o_x_q;
        o_y_d        = o_y_q;
        o_speed_d    = o_speed_q;
        o_dir_d      = o_dir_q;
        o_new_d      = o_new_q;
        o_over_d     = o_over_q;
        o_err_d      = o_err_q;
        mem_we       = 1'b0;

        // A clear seen after acceptance must not be undone by this record's table write.
        if (state_q != IDLE && i_clear) clear_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    id_d         = in_id;
                    x_d          = in_x;
                    y_d          = in_y;
                    stamp_d      = frame_q;
                    clear_pend_d = 1'b0;
                    state_d      = READ;
                end
            end
            READ: state_d = CALC;
            CALC: begin
                new_d   = !prev_valid || (int'(dt_calc) > MAX_GAP);
                err_d   = prev_valid && (dt_calc == '0);
                dir_d   = (y_q < prev_y);
                dt_d    = dt_calc;
                num_d   = NUM_W'(dy_calc) * NUM_W'(SCALE);
                rem_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                rem_d = rem_fits ? rem_diff[FRAME_W-1:0] : rem_shift[FRAME_W-1:0];
                num_d = {num_q[NUM_W-2:0], rem_fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_W - 1)) state_d = DONE;
            end
            DONE: begin
                o_valid_d = 1'b1;
                o_id_d    = id_q;
                o_x_d     = x_q;
                o_y_d     = y_q;
                o_speed_d = speed;
                o_dir_d   = dir_q;
                o_new_d   = new_q;
                o_err_d   = err_q;
                o_over_d  = !new_q && !err_q && (speed > i_limit);
                if (!err_q && !clear_pend_q && !i_clear) begin
                    mem_we        = 1'b1;
                    valid_d[id_q] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_clear) valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            valid_q      <= '0;
            clear_pend_q <= 1'b0;
            id_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            stamp_q      <= '0;
            new_q        <= 1'b0;
            err_q        <= 1'b0;
            dir_q        <= 1'b0;
            dt_q         <= '0;
            num_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            o_valid_q    <= 1'b0;
            o_id_q       <= '0;
            o_x_q        <= '0;
            o_y_q        <= '0;
            o_speed_q    <= '0;
            o_dir_q      <= 1'b0;
            o_new_q      <= 1'b0;
            o_over_q     <= 1'b0;
            o_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            valid_q      <= valid_d;
            clear_pend_q <= clear_pend_d;
            id_q         <= id_d;
            x_q          <= x_d;
            y_q          <= y_d;
            stamp_q      <= stamp_d;
            new_q        <= new_d;
            err_q        <= err_d;
            dir_q        <= dir_d;
            dt_q         <= dt_d;
            num_q        <= num_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            o_valid_q    <= o_valid_d;
            o_id_q       <= o_id_d;
            o_x_q        <= o_x_d;
            o_y_q        <= o_y_d;
            o_speed_q    <= o_speed_d;
            o_dir_q      <= o_dir_d;
            o_new_q      <= o_new_d;
            o_over_q     <= o_over_d;
            o_err_q      <= o_err_d;
        end
    end

    // History storage has no reset; the valid flops decide whether an entry means anything.
    always_ff @(posedge clk) begin
        if (mem_we) mem[id_q] <= {x_q, y_q, stamp_q};
        rd_q <= mem[id_q];
    end

endmodule
